// File: rtl/noc_leaf_injector.sv
// noc_leaf_injector
//   Credit-based injection stage between a traffic source and a NoC leaf_rx
//   port. Packets arrive on a valid/ready stream tagged with a VC index and
//   leave one cycle later on a registered one-hot vc_target/packet pair.
//   One credit counter per VC tracks free slots in the downstream VC FIFO.
//
// Ports
//   clk, rst_n        clock (posedge) and synchronous active-low reset
//   in_valid/ready    source handshake; in_vc selects the VC, in_packet = {addr, data}
//   tx_vc_target      one-hot VC of the packet on tx_packet, all-zero when idle
//   tx_packet         packet to topology leaf_rx (holds last value when idle)
//   rx_vc_credit_gnt  per-VC credit-return pulses from the topology
//   credits           packed per-VC credit counts, VC i at [i*CR_W +: CR_W]
//   pkt_count         packets sent since reset, wraps modulo 2^32
//   err_bad_vc        sticky: in_valid seen with in_vc >= VC_W
//   err_credit_ovf    sticky: credit returned to a VC already at full depth
module noc_leaf_injector #(
    parameter int unsigned VC_W          = 2,
    parameter int unsigned A_W           = 4,
    parameter int unsigned D_W           = 32,
    parameter int unsigned VC_FIFO_DEPTH = 8,
    localparam int unsigned VCI_W        = (VC_W > 1) ? $clog2(VC_W) : 1,
    localparam int unsigned CR_W         = $clog2(VC_FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [VCI_W-1:0]     in_vc,
    input  logic [A_W+D_W-1:0]   in_packet,
    output logic [VC_W-1:0]      tx_vc_target,
    output logic [A_W+D_W-1:0]   tx_packet,
    input  logic [VC_W-1:0]      rx_vc_credit_gnt,
    output logic [VC_W*CR_W-1:0] credits,
    output logic [31:0]          pkt_count,
    output logic                 err_bad_vc,
    output logic                 err_credit_ovf
);

    localparam logic [CR_W-1:0] CR_MAX = CR_W'(VC_FIFO_DEPTH);

    logic [CR_W-1:0] credit_q [VC_W];
    logic [CR_W-1:0] credit_d [VC_W];
    logic            vc_ok;
    logic            sel_has_credit;
    logic            fire;
    logic            ovf_hit;

    // Acceptance looks only at registered counts, so a credit returned on
    // this edge becomes usable no earlier than the next cycle.
    always_comb begin
        vc_ok          = 32'(in_vc) < VC_W;
        sel_has_credit = 1'b0;
        for (int unsigned i = 0; i < VC_W; i++) begin
            if (32'(in_vc) == i && credit_q[i] != '0) begin
                sel_has_credit = 1'b1;
            end
        end
        in_ready = rst_n && vc_ok && sel_has_credit;
        fire     = in_valid && in_ready;
    end

    // Per-VC next credit: a send and a return on the same edge cancel out;
    // a lone return at full depth saturates and flags overflow.
    always_comb begin
        ovf_hit = 1'b0;
        credits = '0;
        for (int unsigned i = 0; i < VC_W; i++) begin
            credit_d[i] = credit_q[i];
            if (fire && 32'(in_vc) == i && !rx_vc_credit_gnt[i]) begin
                credit_d[i] = credit_q[i] - CR_W'(1);
            end else if (rx_vc_credit_gnt[i] && !(fire && 32'(in_vc) == i)) begin
                if (credit_q[i] == CR_MAX) begin
                    ovf_hit = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + CR_W'(1);
                end
            end
            credits[i*CR_W +: CR_W] = credit_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < VC_W; i++) begin
                credit_q[i] <= CR_MAX;
            end
            tx_vc_target   <= '0;
            tx_packet      <= '0;
            pkt_count      <= '0;
            err_bad_vc     <= 1'b0;
            err_credit_ovf <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < VC_W; i++) begin
                credit_q[i] <= credit_d[i];
            end
            tx_vc_target <= '0;
            if (fire) begin
                tx_vc_target <= VC_W'(1) << in_vc;
                tx_packet    <= in_packet;
                pkt_count    <= pkt_count + 32'd1;
            end
            if (in_valid && !vc_ok) begin
                err_bad_vc <= 1'b1;
            end
            if (ovf_hit) begin
                err_credit_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_leaf_injector.sv
// tb_noc_leaf_injector
//   Directed checks of reset, credit exhaustion/return, simultaneous
//   send+return, overflow, bad VC (VC_W=3 instance), then random traffic
//   against a depth-8 sink model.
module tb_noc_leaf_injector;

    logic        clk = 1'b0;
    logic        rst_n;

    // VC_W = 2 instance
    logic        in_valid;
    logic        in_ready;
    logic [0:0]  in_vc;
    logic [35:0] in_packet;
    logic [1:0]  tx_vc_target;
    logic [35:0] tx_packet;
    logic [1:0]  gnt;
    logic [7:0]  credits;
    logic [31:0] pkt_count;
    logic        err_bad_vc;
    logic        err_credit_ovf;

    // VC_W = 3 instance
    logic        b_in_valid;
    logic        b_in_ready;
    logic [1:0]  b_in_vc;
    logic [35:0] b_in_packet;
    logic [2:0]  b_tx_vc_target;
    logic [35:0] b_tx_packet;
    logic [2:0]  b_gnt;
    logic [11:0] b_credits;
    logic [31:0] b_pkt_count;
    logic        b_err_bad_vc;
    logic        b_err_credit_ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    noc_leaf_injector #(.VC_W(2), .A_W(4), .D_W(32), .VC_FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_vc(in_vc), .in_packet(in_packet),
        .tx_vc_target(tx_vc_target), .tx_packet(tx_packet),
        .rx_vc_credit_gnt(gnt), .credits(credits), .pkt_count(pkt_count),
        .err_bad_vc(err_bad_vc), .err_credit_ovf(err_credit_ovf)
    );

    noc_leaf_injector #(.VC_W(3), .A_W(4), .D_W(32), .VC_FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vc(b_in_vc), .in_packet(b_in_packet),
        .tx_vc_target(b_tx_vc_target), .tx_packet(b_tx_packet),
        .rx_vc_credit_gnt(b_gnt), .credits(b_credits), .pkt_count(b_pkt_count),
        .err_bad_vc(b_err_bad_vc), .err_credit_ovf(b_err_credit_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] pk(input int n);
        return {4'(n), 32'hA000_0000 + 32'(n)};
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int mcr [2];
        int occ [2];
        int sent;
        int v;
        logic val;
        logic exp_ready;
        logic fired;
        logic [1:0] g;

        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_vc       = '0;
        in_packet   = pk(99);
        gnt         = '0;
        b_in_valid  = 1'b0;
        b_in_vc     = '0;
        b_in_packet = '0;
        b_gnt       = '0;

        // 1: reset held three cycles with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ready", in_ready, 1'b0);
        end
        check("rst_tx", tx_vc_target, 2'b00);
        check("rst_txpkt", tx_packet, 36'd0);
        check("rst_credits", credits, 8'h88);
        check("rst_pkt", pkt_count, 32'd0);
        check("rst_errs", {err_bad_vc, err_credit_ovf}, 2'b00);

        // 2: VC0 stream of 10 packets, no credit returns
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_vc     = 1'b0;
        in_packet = pk(0);
        for (int n = 0; n < 10; n++) begin
            #1;
            check("exh_ready", in_ready, (n < 8) ? 1'b1 : 1'b0);
            step();
            check("exh_tx", tx_vc_target, (n < 8) ? 2'b01 : 2'b00);
            if (n < 8) begin
                check("exh_pkt", tx_packet, pk(n));
                in_packet = pk(n + 1);
            end
        end
        check("exh_cr0", credits[3:0], 4'd0);
        check("exh_cr1", credits[7:4], 4'd8);
        check("exh_count", pkt_count, 32'd8);
        check("exh_ready_end", in_ready, 1'b0);

        // 3: single credit return on VC0
        gnt = 2'b01;
        #1;
        check("ret_nobypass", in_ready, 1'b0);
        step();
        gnt = 2'b00;
        #1;
        check("ret_ready", in_ready, 1'b1);
        check("ret_cr0", credits[3:0], 4'd1);
        check("ret_idle", tx_vc_target, 2'b00);
        step();
        check("ret_tx", tx_vc_target, 2'b01);
        check("ret_pkt", tx_packet, pk(8));
        check("ret_cr0b", credits[3:0], 4'd0);
        check("ret_count", pkt_count, 32'd9);
        in_packet = pk(9);
        #1;
        check("ret_ready2", in_ready, 1'b0);
        step();
        check("ret_tx2", tx_vc_target, 2'b00);
        in_valid = 1'b0;

        // 4: VC1 down to 3, then send + return on the same edge
        in_vc    = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_packet = pk(20 + k);
            step();
        end
        check("sim_cr1_pre", credits[7:4], 4'd3);
        in_packet = pk(25);
        gnt       = 2'b10;
        #1;
        check("sim_ready", in_ready, 1'b1);
        step();
        gnt      = 2'b00;
        in_valid = 1'b0;
        check("sim_cr1", credits[7:4], 4'd3);
        check("sim_tx", tx_vc_target, 2'b10);
        check("sim_pkt", tx_packet, pk(25));
        check("sim_count", pkt_count, 32'd15);
        step();
        check("sim_idle", tx_vc_target, 2'b00);
        check("sim_hold", tx_packet, pk(25));

        // 5: refill VC0 to 8, then one extra return overflows
        gnt = 2'b01;
        for (int k = 0; k < 8; k++) step();
        check("ovf_cr0_full", credits[3:0], 4'd8);
        check("ovf_clear", err_credit_ovf, 1'b0);
        step();
        gnt = 2'b00;
        check("ovf_cr0_sat", credits[3:0], 4'd8);
        check("ovf_set", err_credit_ovf, 1'b1);
        for (int k = 0; k < 3; k++) step();
        check("ovf_sticky", err_credit_ovf, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("ovf_rst", err_credit_ovf, 1'b0);
        check("ovf_rst_cr", credits, 8'h88);
        check("ovf_rst_cnt", pkt_count, 32'd0);

        // 6: VC_W=3 instance, out-of-range VC index
        b_in_valid  = 1'b1;
        b_in_vc     = 2'd3;
        b_in_packet = pk(40);
        #1;
        check("bad_ready", b_in_ready, 1'b0);
        step();
        check("bad_err", b_err_bad_vc, 1'b1);
        check("bad_tx", b_tx_vc_target, 3'b000);
        check("bad_cnt", b_pkt_count, 32'd0);
        b_in_vc = 2'd2;
        #1;
        check("b_vc2_ready", b_in_ready, 1'b1);
        step();
        b_in_valid = 1'b0;
        check("b_vc2_tx", b_tx_vc_target, 3'b100);
        check("b_vc2_cr", b_credits, 12'h788);
        check("b_err_sticky", b_err_bad_vc, 1'b1);
        check("b_cnt", b_pkt_count, 32'd1);

        // Random traffic into a depth-8 sink that drains at random
        mcr[0] = 8; mcr[1] = 8;
        occ[0] = 0; occ[1] = 0;
        sent   = 0;
        for (int c = 0; c < 300; c++) begin
            v   = int'($urandom_range(0, 1));
            val = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                g[i] = (occ[i] > 0) && ($urandom_range(0, 2) == 0);
            end
            in_valid  = val;
            in_vc     = 1'(v);
            in_packet = pk(100 + c);
            gnt       = g;
            #1;
            exp_ready = (mcr[v] != 0);
            check("rnd_ready", in_ready, exp_ready);
            fired = val && exp_ready;
            if (fired) begin
                mcr[v]--;
                occ[v]++;
                sent++;
            end
            for (int i = 0; i < 2; i++) begin
                if (g[i]) begin
                    mcr[i]++;
                    occ[i]--;
                end
            end
            step();
            check("rnd_tx", tx_vc_target, fired ? (2'b01 << v) : 2'b00);
            check("rnd_credits", credits, {4'(mcr[1]), 4'(mcr[0])});
            check("rnd_range", (credits[3:0] <= 4'd8) && (credits[7:4] <= 4'd8), 1'b1);
        end
        in_valid = 1'b0;
        gnt      = '0;
        check("rnd_count", pkt_count, 32'(sent));
        check("rnd_errs", {err_bad_vc, err_credit_ovf}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
